// File: rtl/fetch_queue_unit.sv
// Fetch unit: PC register, one-outstanding I-cache request, FQ_DEPTH-entry instruction FIFO to decode.
// Optional performance counters enabled by defining FETCH_PERF_EN.
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  output logic            IC_REQ_V,
  output logic [XLEN-1:0] IC_REQ_PC,
  input  logic            IC_REQ_RDY,
  input  logic            IC_RESP_V,
  input  logic [ILEN-1:0] IC_RESP_INSTR,
  input  logic            IC_RESP_FAULT,
  input  logic            BR_STALL,
  input  logic            REDIRECT_V,
  input  logic [XLEN-1:0] REDIRECT_PC,
  input  logic            TRAP_V,
  input  logic [XLEN-1:0] DE_MTVEC,
  input  logic            DE_RDY,
  output logic            DE_V,
  output logic [ILEN-1:0] DE_IR,
  output logic [XLEN-1:0] DE_PC,
  output logic [XLEN-1:0] DE_NPC,
  output logic            F_IAM,
  output logic            F_IAF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     PERF_FETCHED,
  output logic [31:0]     PERF_FLUSHES,
  output logic [31:0]     PERF_STALL_CYC
`endif
);

  localparam int unsigned AW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN, S_HALT} state_t;

  state_t            state;
  logic [XLEN-1:0]   fe_pc;
  logic [ILEN-1:0]   ir_q [FQ_DEPTH];
  logic [XLEN-1:0]   pc_q [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] iam_q;
  logic [FQ_DEPTH-1:0] iaf_q;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic            redirect;
  logic            misaligned;
  logic [CW-1:0]   occupied;
  logic            space_ok;
  logic            can_issue;
  logic            req_v;
  logic            req_fire;
  logic            iam_enq;
  logic            resp_enq;
  logic            enq;
  logic            pop;
  logic [ILEN-1:0] enq_ir;
  logic            enq_iaf;

  // An outstanding request holds a slot so its response always has room.
  always_comb begin
    redirect   = TRAP_V | REDIRECT_V;
    misaligned = |fe_pc[1:0];
    occupied   = count + {{(CW-1){1'b0}}, (state == S_WAIT)};
    space_ok   = occupied < CW'(FQ_DEPTH);
    can_issue  = !RESET && (state == S_RUN) && !BR_STALL && space_ok;
    req_v      = can_issue && !misaligned;
    req_fire   = req_v && IC_REQ_RDY;
    iam_enq    = can_issue && misaligned;
    resp_enq   = (state == S_WAIT) && IC_RESP_V;
    enq        = !redirect && (iam_enq || resp_enq);
    pop        = DE_V && DE_RDY && !redirect;
    enq_ir     = iam_enq ? '0 : IC_RESP_INSTR;
    enq_iaf    = resp_enq && IC_RESP_FAULT;
  end

  assign IC_REQ_V  = req_v;
  assign IC_REQ_PC = fe_pc;
  assign DE_V      = (count != '0);
  assign DE_IR     = ir_q[rd_ptr];
  assign DE_PC     = pc_q[rd_ptr];
  assign DE_NPC    = pc_q[rd_ptr] + XLEN'(4);
  assign F_IAM     = DE_V & iam_q[rd_ptr];
  assign F_IAF     = DE_V & iaf_q[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_RUN;
      fe_pc  <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fe_pc  <= TRAP_V ? DE_MTVEC : REDIRECT_PC;
      // A request still owed a response must have that response swallowed.
      if (req_fire || ((state == S_WAIT) && !IC_RESP_V)) state <= S_DRAIN;
      else                                                 state <= S_RUN;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (enq && !pop)      count <= count + CW'(1);
      else if (!enq && pop) count <= count - CW'(1);
      case (state)
        S_RUN: begin
          if (req_fire)     state <= S_WAIT;
          else if (iam_enq) state <= S_HALT;
        end
        S_WAIT: begin
          if (IC_RESP_V) begin
            if (IC_RESP_FAULT) state <= S_HALT;
            else begin
              fe_pc <= fe_pc + XLEN'(4);
              state <= S_RUN;
            end
          end
        end
        S_DRAIN: if (IC_RESP_V) state <= S_RUN;
        S_HALT:  state <= S_HALT;
        default: state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      ir_q[wr_ptr]  <= enq_ir;
      pc_q[wr_ptr]  <= fe_pc;
      iam_q[wr_ptr] <= iam_enq;
      iaf_q[wr_ptr] <= enq_iaf;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PERF_FETCHED   <= '0;
      PERF_FLUSHES   <= '0;
      PERF_STALL_CYC <= '0;
    end else begin
      if (enq)      PERF_FETCHED <= PERF_FETCHED + 32'd1;
      if (redirect) PERF_FLUSHES <= PERF_FLUSHES + 32'd1;
      if ((state == S_WAIT) || (state == S_DRAIN))
        PERF_STALL_CYC <= PERF_STALL_CYC + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed self-checking bench for fetch_queue_unit (RESET_PC=0x1000, FQ_DEPTH=4).
module tb_fetch_queue_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IC_REQ_V;
  logic [63:0] IC_REQ_PC;
  logic        IC_REQ_RDY;
  logic        IC_RESP_V;
  logic [31:0] IC_RESP_INSTR;
  logic        IC_RESP_FAULT;
  logic        BR_STALL;
  logic        REDIRECT_V;
  logic [63:0] REDIRECT_PC;
  logic        TRAP_V;
  logic [63:0] DE_MTVEC;
  logic        DE_RDY;
  logic        DE_V;
  logic [31:0] DE_IR;
  logic [63:0] DE_PC;
  logic [63:0] DE_NPC;
  logic        F_IAM;
  logic        F_IAF;
`ifdef FETCH_PERF_EN
  logic [31:0] PERF_FETCHED, PERF_FLUSHES, PERF_STALL_CYC;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 CLK = ~CLK;

  fetch_queue_unit #(
    .XLEN(64), .ILEN(32), .FQ_DEPTH(4), .RESET_PC(64'h1000)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .IC_REQ_V(IC_REQ_V), .IC_REQ_PC(IC_REQ_PC), .IC_REQ_RDY(IC_REQ_RDY),
    .IC_RESP_V(IC_RESP_V), .IC_RESP_INSTR(IC_RESP_INSTR), .IC_RESP_FAULT(IC_RESP_FAULT),
    .BR_STALL(BR_STALL), .REDIRECT_V(REDIRECT_V), .REDIRECT_PC(REDIRECT_PC),
    .TRAP_V(TRAP_V), .DE_MTVEC(DE_MTVEC), .DE_RDY(DE_RDY),
    .DE_V(DE_V), .DE_IR(DE_IR), .DE_PC(DE_PC), .DE_NPC(DE_NPC),
    .F_IAM(F_IAM), .F_IAF(F_IAF)
`ifdef FETCH_PERF_EN
    , .PERF_FETCHED(PERF_FETCHED), .PERF_FLUSHES(PERF_FLUSHES), .PERF_STALL_CYC(PERF_STALL_CYC)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Call in a cycle where a request is handshaking; cache answers the next cycle.
  task automatic fetch(input logic [31:0] ins, input logic flt);
    step();
    IC_RESP_V = 1'b1; IC_RESP_INSTR = ins; IC_RESP_FAULT = flt;
    step();
    IC_RESP_V = 1'b0; IC_RESP_FAULT = 1'b0;
    #1;
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    REDIRECT_V = 1'b1; REDIRECT_PC = pc;
    step();
    REDIRECT_V = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    RESET = 1'b1; IC_REQ_RDY = 1'b0; IC_RESP_V = 1'b0; IC_RESP_INSTR = '0;
    IC_RESP_FAULT = 1'b0; BR_STALL = 1'b0; REDIRECT_V = 1'b0; REDIRECT_PC = '0;
    TRAP_V = 1'b0; DE_MTVEC = '0; DE_RDY = 1'b0;
    step(); step();
    check("rst_de_v",  DE_V, 0);
    check("rst_req_v", IC_REQ_V, 0);
    check("rst_iam",   F_IAM, 0);
    check("rst_iaf",   F_IAF, 0);

    // Sequential fetch from RESET_PC with decode always ready
    RESET = 1'b0; IC_REQ_RDY = 1'b1; DE_RDY = 1'b1;
    #1;
    check("seq_req_v0",  IC_REQ_V, 1);
    check("seq_req_pc0", IC_REQ_PC, 64'h1000);
    step();
    IC_RESP_V = 1'b1; IC_RESP_INSTR = 32'hA0;
    #1;
    check("wait_req_v", IC_REQ_V, 0);
    check("wait_de_v",  DE_V, 0);
    step();
    IC_RESP_V = 1'b0;
    #1;
    check("lat_de_v",    DE_V, 1);
    check("seq_de_pc0",  DE_PC, 64'h1000);
    check("seq_npc0",    DE_NPC, 64'h1004);
    check("seq_ir0",     DE_IR, 32'hA0);
    check("seq_req_pc1", IC_REQ_PC, 64'h1004);
    check("seq_req_v1",  IC_REQ_V, 1);
    fetch(32'hA1, 1'b0);
    check("seq_de_pc1",  DE_PC, 64'h1004);
    check("seq_npc1",    DE_NPC, 64'h1008);
    check("seq_req_pc2", IC_REQ_PC, 64'h1008);

    // Redirect without a handshake, then fill the FIFO with decode stalled
    IC_REQ_RDY = 1'b0;
    redirect_to(64'h4000);
    check("rd_flush_de_v", DE_V, 0);
    check("rd_req_pc",     IC_REQ_PC, 64'h4000);
    IC_REQ_RDY = 1'b1; DE_RDY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("fill_req_v",  IC_REQ_V, 1);
      check("fill_req_pc", IC_REQ_PC, 64'h4000 + 64'(4 * i));
      fetch(32'h100 + 32'(i), 1'b0);
    end
    check("full_req_v", IC_REQ_V, 0);
    check("full_head",  DE_PC, 64'h4000);
    DE_RDY = 1'b1;
    #1;
    check("full_pop_req_v", IC_REQ_V, 0);
    step();
    DE_RDY = 1'b0;
    #1;
    check("one_slot_req_v",  IC_REQ_V, 1);
    check("one_slot_req_pc", IC_REQ_PC, 64'h4010);
    fetch(32'h104, 1'b0);
    check("refull_req_v", IC_REQ_V, 0);
    check("refull_head",  DE_PC, 64'h4004);
    check("refull_ir",    DE_IR, 32'h101);

    // Redirect while waiting; stale response arrives 3 cycles after accept
    redirect_to(64'h5000);
    DE_RDY = 1'b1;
    #1;
    check("c_req_pc", IC_REQ_PC, 64'h5000);
    step();
    REDIRECT_V = 1'b1; REDIRECT_PC = 64'h2000;
    step();
    REDIRECT_V = 1'b0;
    #1;
    check("drain_req_v", IC_REQ_V, 0);
    check("drain_de_v",  DE_V, 0);
    step();
    check("drain2_req_v", IC_REQ_V, 0);
    IC_RESP_V = 1'b1; IC_RESP_INSTR = 32'hDEAD;
    step();
    IC_RESP_V = 1'b0;
    #1;
    check("stale_de_v",  DE_V, 0);
    check("post_req_v",  IC_REQ_V, 1);
    check("post_req_pc", IC_REQ_PC, 64'h2000);
    step();
    check("post_wait_de_v", DE_V, 0);
    IC_RESP_V = 1'b1; IC_RESP_INSTR = 32'hB0;
    step();
    IC_RESP_V = 1'b0;
    #1;
    check("post_de_v",  DE_V, 1);
    check("post_de_pc", DE_PC, 64'h2000);
    check("post_ir",    DE_IR, 32'hB0);

    // Trap wins over branch redirect
    IC_REQ_RDY = 1'b0;
    TRAP_V = 1'b1; DE_MTVEC = 64'h80;
    redirect_to(64'h2000);
    TRAP_V = 1'b0;
    #1;
    check("trap_pc",   IC_REQ_PC, 64'h80);
    check("trap_de_v", DE_V, 0);
    check("trap_req_v", IC_REQ_V, 1);

    // Misaligned target
    redirect_to(64'h2002);
    IC_REQ_RDY = 1'b1; DE_RDY = 1'b0;
    #1;
    check("iam_no_req", IC_REQ_V, 0);
    step();
    check("iam_de_v",  DE_V, 1);
    check("iam_flag",  F_IAM, 1);
    check("iam_iaf",   F_IAF, 0);
    check("iam_pc",    DE_PC, 64'h2002);
    check("iam_ir",    DE_IR, 0);
    step(); step(); step();
    check("halt_req_v", IC_REQ_V, 0);
    check("halt_de_v",  DE_V, 1);
    redirect_to(64'h3000);
    check("unhalt_req_v",  IC_REQ_V, 1);
    check("unhalt_req_pc", IC_REQ_PC, 64'h3000);
    check("unhalt_de_v",   DE_V, 0);

    // Access fault
    fetch(32'hC0, 1'b1);
    check("iaf_de_v",  DE_V, 1);
    check("iaf_flag",  F_IAF, 1);
    check("iaf_iam",   F_IAM, 0);
    check("iaf_pc",    DE_PC, 64'h3000);
    check("iaf_req_v", IC_REQ_V, 0);
    check("iaf_hold",  IC_REQ_PC, 64'h3000);
    step(); step();
    check("iaf_halt_req_v", IC_REQ_V, 0);

    // Reset in the middle of WAIT beats a same-cycle response
    redirect_to(64'h3100);
    step();
    RESET = 1'b1; IC_RESP_V = 1'b1; IC_RESP_INSTR = 32'hE0;
    step();
    RESET = 1'b0; IC_RESP_V = 1'b0;
    #1;
    check("mid_rst_de_v",   DE_V, 0);
    check("mid_rst_pc",     IC_REQ_PC, 64'h1000);
    check("mid_rst_req_v",  IC_REQ_V, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
